// File: rtl/uart_vpp_pkg.sv
// Shared framing constants and state encoding for the VPP-side UART link.
// The board-side master imports this package as well.
package uart_vpp_pkg;

    localparam logic [2:0]  HEAD      = 3'b101;
    localparam logic [2:0]  TAIL      = 3'b010;
    localparam int unsigned FRAME_OVH = 6;

    typedef enum logic [2:0] {
        IDLE,
        RX_START,
        RX_DATA,
        RX_CHECK,
        TURN,
        TX_START,
        TX_DATA,
        TX_STOP
    } state_e;

    function automatic logic marks_ok(input logic [2:0] head, input logic [2:0] tail);
        return (head == HEAD) && (tail == TAIL);
    endfunction

endpackage

// File: rtl/uart_slave_vpp_if.sv
// Pad-side and register-side signals of the VPP UART slave.
interface uart_slave_vpp_if #(
    parameter int unsigned NBIT_IN  = 10,
    parameter int unsigned NBIT_OUT = 10
);
    logic                tick;
    logic                resp_enable;
    logic [NBIT_OUT-1:0] par_data_in;
    logic                ser_data_in;
    logic                ser_data_out;
    logic                ser_oe;
    logic [NBIT_IN-1:0]  par_data_out;
    logic                rx_valid;
    logic                frame_err;
    logic                busy;

    modport slave (
        input  tick, resp_enable, par_data_in, ser_data_in,
        output ser_data_out, ser_oe, par_data_out, rx_valid, frame_err, busy
    );

    modport master (
        output tick, resp_enable, par_data_in, ser_data_in,
        input  ser_data_out, ser_oe, par_data_out, rx_valid, frame_err, busy
    );
endinterface

// File: rtl/uart_slave_vpp_bit_timer.sv
// Tick counter shared by half-bit, full-bit and turnaround timing.
// done_c fires on the tick that completes tc ticks; the count then wraps.
module uart_bit_timer #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             restart,
    input  logic [CNT_W-1:0] tc,
    output logic             done_c
);

    logic [CNT_W-1:0] count_q;

    assign done_c = tick && !restart && (count_q == (tc - CNT_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (restart) begin
            count_q <= '0;
        end else if (tick) begin
            count_q <= done_c ? '0 : count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_slave_vpp.sv
// VPP-side endpoint of the half-duplex framed UART: receives one framed word,
// checks its marks, and after a fixed turnaround answers with one framed word.
module uart_slave_vpp
    import uart_vpp_pkg::*;
#(
    parameter int unsigned NBIT_IN         = 10,
    parameter int unsigned NBIT_OUT        = 10,
    parameter int unsigned BPS_COUNT_NUM   = 48,
    parameter int unsigned START_COUNT_NUM = 24,
    parameter int unsigned TURN_BITS       = 4
) (
    input logic              clk,
    input logic              rst,
    uart_slave_vpp_if.slave  bus
);

    localparam int unsigned RX_W   = NBIT_IN + FRAME_OVH;
    localparam int unsigned TX_W   = NBIT_OUT + FRAME_OVH;
    localparam int unsigned RX_IW  = $clog2(RX_W);
    localparam int unsigned TX_IW  = $clog2(TX_W);
    localparam int unsigned IDX_M  = (RX_W > TX_W) ? RX_W : TX_W;
    localparam int unsigned IDX_N  = (IDX_M > TURN_BITS) ? IDX_M : TURN_BITS;
    localparam int unsigned IDX_W  = $clog2(IDX_N);
    localparam int unsigned CNT_W  = $clog2(BPS_COUNT_NUM + 1);

    state_e              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [RX_W-1:0]     rx_shift_q;
    logic [TX_W-1:0]     tx_shift_q;
    logic                ser_prev_q;
    logic                sdo_q;
    logic                oe_q;
    logic [NBIT_IN-1:0]  pdo_q;
    logic                rx_valid_q;
    logic                frame_err_q;
    logic                busy_q;

    logic                restart_c;
    logic [CNT_W-1:0]    tc_c;
    logic                done_c;

    // Timer is held clear while idle and across the one-clk check state.
    assign restart_c = (state_q == IDLE) || (state_q == RX_CHECK);
    assign tc_c      = (state_q == RX_START) ? CNT_W'(START_COUNT_NUM) : CNT_W'(BPS_COUNT_NUM);

    uart_bit_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .tick    (bus.tick),
        .restart (restart_c),
        .tc      (tc_c),
        .done_c  (done_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            ser_prev_q  <= 1'b1;
            sdo_q       <= 1'b1;
            oe_q        <= 1'b0;
            pdo_q       <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ser_prev_q  <= bus.ser_data_in;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ser_prev_q && !bus.ser_data_in) begin
                        state_q <= RX_START;
                        busy_q  <= 1'b1;
                    end
                end
                RX_START: begin
                    if (done_c) begin
                        idx_q <= '0;
                        if (!bus.ser_data_in) begin
                            state_q <= RX_DATA;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                        end
                    end
                end
                RX_DATA: begin
                    if (done_c) begin
                        rx_shift_q[RX_IW'(idx_q)] <= bus.ser_data_in;
                        if (idx_q == IDX_W'(RX_W - 1)) begin
                            idx_q   <= '0;
                            state_q <= RX_CHECK;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                RX_CHECK: begin
                    if (marks_ok(rx_shift_q[2:0], rx_shift_q[RX_W-1 -: 3])) begin
                        pdo_q      <= rx_shift_q[NBIT_IN+2:3];
                        rx_valid_q <= 1'b1;
                        if (bus.resp_enable) begin
                            state_q <= TURN;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                    end
                end
                TURN: begin
                    if (done_c) begin
                        if (idx_q == IDX_W'(TURN_BITS - 1)) begin
                            tx_shift_q <= {TAIL, bus.par_data_in, HEAD};
                            idx_q      <= '0;
                            oe_q       <= 1'b1;
                            sdo_q      <= 1'b0;
                            state_q    <= TX_START;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                TX_START: begin
                    if (done_c) begin
                        sdo_q   <= tx_shift_q[0];
                        idx_q   <= '0;
                        state_q <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (done_c) begin
                        if (idx_q == IDX_W'(TX_W - 1)) begin
                            sdo_q   <= 1'b1;
                            idx_q   <= '0;
                            state_q <= TX_STOP;
                        end else begin
                            sdo_q <= tx_shift_q[TX_IW'(idx_q + IDX_W'(1))];
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                TX_STOP: begin
                    if (done_c) begin
                        oe_q    <= 1'b0;
                        sdo_q   <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    oe_q    <= 1'b0;
                    sdo_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ser_data_out = sdo_q;
    assign bus.ser_oe       = oe_q;
    assign bus.par_data_out = pdo_q;
    assign bus.rx_valid     = rx_valid_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_uart_slave_vpp.sv
// Bench for uart_slave_vpp: table of framed exchanges plus reset, glitch and
// late par_data_in sequences, with queue scoreboards for received and sent words.
module tb_uart_slave_vpp;
    import uart_vpp_pkg::*;

    localparam int unsigned NB    = 10;
    localparam int unsigned BPS   = 48;
    localparam int unsigned START = 24;
    localparam int unsigned TURNB = 4;
    localparam int unsigned FW    = NB + 6;
    localparam int          NOM_GAP = 48 * 16 + 24 + 4 * 48;

    typedef struct {
        logic [NB-1:0] pay;
        logic [2:0]    head;
        logic [2:0]    tail;
        logic          resp;
        logic [NB-1:0] pin;
        int            exp_valid;
        int            exp_err;
        int            exp_tx;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic master_drv = 1'b1;
    always #5 clk = ~clk;

    uart_slave_vpp_if #(.NBIT_IN(NB), .NBIT_OUT(NB)) bif ();
    assign bif.ser_data_in = bif.ser_oe ? bif.ser_data_out : master_drv;

    uart_slave_vpp #(
        .NBIT_IN(NB), .NBIT_OUT(NB), .BPS_COUNT_NUM(BPS),
        .START_COUNT_NUM(START), .TURN_BITS(TURNB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_rxv = 0, n_ferr = 0, n_tx = 0, n_oe = 0;
    int rise_cyc = 0, frame_start_cyc = 0;
    logic [NB-1:0] last_good = '0;
    logic [NB-1:0] rx_q[$];
    logic [FW+1:0] tx_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line/scoreboard monitor, sampled on the falling clock edge.
    initial begin : monitor
        logic          tx_active;
        logic          oe_prev;
        logic          oe_ok;
        int            tx_cnt;
        logic [FW+1:0] cap;
        logic [FW+1:0] exp_f;
        tx_active = 1'b0;
        oe_prev   = 1'b0;
        oe_ok     = 1'b1;
        tx_cnt    = 0;
        cap       = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                tx_active = 1'b0;
                oe_prev   = 1'b0;
            end else begin
                if (bif.ser_oe) n_oe++;
                if (!bif.ser_oe && !bif.ser_data_out) begin
                    total++; bad++;
                    $display("FAIL idle_drive: ser_data_out=0 while ser_oe=0 at cyc %0d", cyc);
                end
                if (bif.rx_valid || bif.frame_err) begin
                    total++;
                    if (bif.rx_valid && bif.frame_err) begin
                        bad++;
                        $display("FAIL pulse_excl: rx_valid and frame_err both 1 at cyc %0d", cyc);
                    end
                end
                if (bif.frame_err) n_ferr++;
                if (bif.rx_valid) begin
                    n_rxv++;
                    if (rx_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL rx_unexpected: got %0h expected none", bif.par_data_out);
                    end else begin
                        chk("rx_payload", 32'(bif.par_data_out), 32'(rx_q.pop_front()));
                    end
                end
                if (!tx_active && bif.ser_oe && !oe_prev) begin
                    tx_active = 1'b1;
                    tx_cnt    = 0;
                    oe_ok     = 1'b1;
                    rise_cyc  = cyc;
                end else if (tx_active) begin
                    tx_cnt++;
                end
                if (tx_active && tx_cnt >= 24 && ((tx_cnt - 24) % 48) == 0) begin
                    cap[(tx_cnt - 24) / 48] = bif.ser_data_out;
                    oe_ok = oe_ok & bif.ser_oe;
                    if ((tx_cnt - 24) / 48 == FW + 1) begin
                        tx_active = 1'b0;
                        n_tx++;
                        chk("tx_oe_held", 32'(oe_ok), 32'd1);
                        if (tx_q.size() == 0) begin
                            total++; bad++;
                            $display("FAIL tx_unexpected: got %0h expected none", cap);
                        end else begin
                            exp_f = tx_q.pop_front();
                            chk("tx_frame", 32'(cap), 32'(exp_f));
                        end
                    end
                end
                oe_prev = bif.ser_oe;
            end
        end
    end

    task automatic drive_bit(input logic b);
        master_drv = b;
        repeat (BPS) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [NB-1:0] pay, input logic [2:0] head, input logic [2:0] tail);
        logic [FW-1:0] bits;
        bits = {tail, pay, head};
        @(posedge clk); #1;
        frame_start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < int'(FW); i++) drive_bit(bits[i]);
        master_drv = 1'b1;
    endtask

    task automatic wait_oe(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            if (bif.ser_oe) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [FW+1:0] tx_word(input logic [NB-1:0] pin);
        return {1'b1, TAIL, pin, HEAD, 1'b0};
    endfunction

    initial begin : main
        vec_t vecs[6];
        int   s_rxv, s_ferr, s_tx, s_oe, g;
        logic ok;

        bif.tick        = 1'b1;
        bif.resp_enable = 1'b0;
        bif.par_data_in = '0;
        repeat (3) @(posedge clk); #1;
        chk("rst_sdo",   32'(bif.ser_data_out), 32'd1);
        chk("rst_oe",    32'(bif.ser_oe),       32'd0);
        chk("rst_pdo",   32'(bif.par_data_out), 32'd0);
        chk("rst_rxv",   32'(bif.rx_valid),     32'd0);
        chk("rst_ferr",  32'(bif.frame_err),    32'd0);
        chk("rst_busy",  32'(bif.busy),         32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk); #1;

        vecs[0] = '{10'h2A5, 3'b101, 3'b010, 1'b1, 10'h155, 1, 0, 1};
        vecs[1] = '{10'h2A5, 3'b100, 3'b010, 1'b1, 10'h155, 0, 1, 0};
        vecs[2] = '{10'h3FF, 3'b101, 3'b010, 1'b0, 10'h0AA, 1, 0, 0};
        vecs[3] = '{10'h000, 3'b101, 3'b010, 1'b1, 10'h3FF, 1, 0, 1};
        vecs[4] = '{10'h0F0, 3'b101, 3'b011, 1'b1, 10'h155, 0, 1, 0};
        vecs[5] = '{10'h155, 3'b101, 3'b010, 1'b1, 10'h000, 1, 0, 1};

        for (int i = 0; i < 6; i++) begin
            s_rxv = n_rxv; s_ferr = n_ferr; s_tx = n_tx; s_oe = n_oe;
            bif.resp_enable = vecs[i].resp;
            bif.par_data_in = vecs[i].pin;
            if (vecs[i].exp_valid != 0) begin
                rx_q.push_back(vecs[i].pay);
                last_good = vecs[i].pay;
            end
            if (vecs[i].exp_tx != 0) tx_q.push_back(tx_word(vecs[i].pin));
            send_frame(vecs[i].pay, vecs[i].head, vecs[i].tail);
            repeat (1200) @(posedge clk); #1;
            chk($sformatf("v%0d_rxv", i),  32'(n_rxv - s_rxv),   32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_ferr", i), 32'(n_ferr - s_ferr), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_tx", i),   32'(n_tx - s_tx),     32'(vecs[i].exp_tx));
            chk($sformatf("v%0d_pdo", i),  32'(bif.par_data_out), 32'(last_good));
            chk($sformatf("v%0d_busy", i), 32'(bif.busy),         32'd0);
            if (vecs[i].exp_tx == 0) chk($sformatf("v%0d_no_oe", i), 32'(n_oe - s_oe), 32'd0);
            if (i == 0) begin
                g = rise_cyc - frame_start_cyc;
                chk("turn_gap", (g >= NOM_GAP - 3 && g <= NOM_GAP + 3) ? 32'(NOM_GAP) : 32'(g), 32'(NOM_GAP));
            end
        end

        // Short low glitch on an idle line.
        s_rxv = n_rxv; s_ferr = n_ferr; s_oe = n_oe;
        @(posedge clk); #1;
        master_drv = 1'b0;
        repeat (10) @(posedge clk); #1;
        master_drv = 1'b1;
        repeat (100) @(posedge clk); #1;
        chk("glitch_ferr", 32'(n_ferr - s_ferr), 32'd1);
        chk("glitch_rxv",  32'(n_rxv - s_rxv),   32'd0);
        chk("glitch_busy", 32'(bif.busy),        32'd0);
        chk("glitch_oe",   32'(n_oe - s_oe),     32'd0);

        // Reset in the middle of the response data bits.
        bif.resp_enable = 1'b1;
        bif.par_data_in = 10'h0F0;
        rx_q.push_back(10'h1C7);
        tx_q.push_back(tx_word(10'h0F0));
        send_frame(10'h1C7, HEAD, TAIL);
        wait_oe(ok);
        chk("rst_seq_oe_seen", 32'(ok), 32'd1);
        repeat (4 * BPS) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        void'(tx_q.pop_back());
        last_good = '0;
        #1;
        chk("midtx_rst_oe",   32'(bif.ser_oe),       32'd0);
        chk("midtx_rst_sdo",  32'(bif.ser_data_out), 32'd1);
        chk("midtx_rst_busy", 32'(bif.busy),         32'd0);
        chk("midtx_rst_pdo",  32'(bif.par_data_out), 32'd0);
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk); #1;
        s_rxv = n_rxv; s_oe = n_oe;
        bif.resp_enable = 1'b0;
        rx_q.push_back(10'h1A3);
        last_good = 10'h1A3;
        send_frame(10'h1A3, HEAD, TAIL);
        repeat (300) @(posedge clk); #1;
        chk("post_rst_rxv", 32'(n_rxv - s_rxv),   32'd1);
        chk("post_rst_pdo", 32'(bif.par_data_out), 32'h1A3);
        chk("post_rst_oe",  32'(n_oe - s_oe),      32'd0);

        // par_data_in changes after the latch must not reach the line.
        s_tx = n_tx;
        bif.resp_enable = 1'b1;
        bif.par_data_in = 10'h2C3;
        rx_q.push_back(10'h0F5);
        last_good = 10'h0F5;
        tx_q.push_back(tx_word(10'h2C3));
        send_frame(10'h0F5, HEAD, TAIL);
        wait_oe(ok);
        chk("late_pin_oe_seen", 32'(ok), 32'd1);
        repeat (BPS + 3 * BPS + 10) @(posedge clk); #1;
        bif.par_data_in = 10'h13C;
        repeat (1000) @(posedge clk); #1;
        chk("late_pin_tx",    32'(n_tx - s_tx),      32'd1);
        chk("late_pin_pdo",   32'(bif.par_data_out), 32'(last_good));
        chk("tx_q_drained",   32'(tx_q.size()),      32'd0);
        chk("rx_q_drained",   32'(rx_q.size()),      32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_slave_vpp.md
Name: uart_slave_vpp

Overview:
- Remote (VPP-side) endpoint of the single-wire, half-duplex framed UART link driven by the board-side master.
- Receives one framed word from the master, checks the framing, and presents the payload.
- After a fixed turnaround, drives one framed response word back on the same wire.
- Sits between the pad/IO buffer (ser_data_in, ser_data_out, ser_oe) and local status/control registers (par_data_in, par_data_out).

Parameters:
- NBIT_IN, 10, payload bits received from the master; equals the master's NBIT_OUT.
- NBIT_OUT, 10, payload bits sent back; equals the master's NBIT_IN.
- BPS_COUNT_NUM, 48, tick pulses per bit period.
- START_COUNT_NUM, 24, tick pulses from the start-bit falling edge to the first sample point; normally BPS_COUNT_NUM/2.
- TURN_BITS, 4, idle bit periods between the last received sample and the response start bit.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active high
- tick  in  1  one-clk baud prescaler strobe
- resp_enable  in  1  when 1, answer valid frames; when 0, receive only
- par_data_in  in  NBIT_OUT  response payload, sampled at the start of TX
- ser_data_in  in  1  line input, already synchronised upstream
- ser_data_out  out  1  line drive value
- ser_oe  out  1  1 = block drives the line
- par_data_out  out  NBIT_IN  last good received payload
- rx_valid  out  1  one-clk pulse on a good frame
- frame_err  out  1  one-clk pulse on a bad frame or a rejected start bit
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: ser_data_out=1, ser_oe=0, par_data_out=0, rx_valid=0, frame_err=0, busy=0. State goes to IDLE and all counters clear. Reset mid-frame aborts immediately and releases the line in the same cycle (asynchronous).
- Frame on the wire, LSB first: start bit 0, then FRAME={3'b010, payload, 3'b101} bit 0 first, giving NBIT+6 bits; this leads with 1,0,1 and ends with 0,1,0. The response adds one stop bit of 1 after the frame.
- Bit counter advances only on tick. It clears on every state change and at BPS_COUNT_NUM.
- State IDLE: ser_oe=0. A falling edge on ser_data_in (previous 1, current 0) goes to RX_START.
- State RX_START: after START_COUNT_NUM ticks, sample the line.
  - If 0, go to RX_DATA with bit index 0.
  - If 1, pulse frame_err (glitch) and return to IDLE.
- State RX_DATA: sample at each BPS_COUNT_NUM-tick boundary, so sampling stays mid-bit. Shift the sample into rx_shift[index]. After sample NBIT_IN+5, go to RX_CHECK.
- State RX_CHECK (1 clk):
  - Good frame: rx_shift[2:0]==3'b101 and rx_shift[top:top-2]==3'b010. Load par_data_out=rx_shift[NBIT_IN+2:3] and pulse rx_valid in the same cycle. Go to TURN if resp_enable=1, else IDLE.
  - Bad frame: pulse frame_err, leave par_data_out unchanged, go to IDLE.
- State TURN: line stays released for TURN_BITS bit periods. Any falling edge seen in TURN is ignored. Then latch par_data_in into tx_shift and go to TX_START.
- State TX_START: ser_oe=1, ser_data_out=0 for one bit period, then TX_DATA.
- State TX_DATA: ser_data_out=tx_shift[index] for NBIT_OUT+6 bit periods, then TX_STOP.
- State TX_STOP: ser_data_out=1 for one bit period, then ser_oe=0 and go to IDLE.
- par_data_in changes after the latch have no effect on the frame in flight.
- If tick stops, the block holds its state indefinitely; there is no timeout.
- ser_data_out=1 whenever ser_oe=0.
- rx_valid and frame_err never assert in the same cycle.

Decomposition:
- Package uart_vpp_pkg holds:
  - HEAD=3'b101 and TAIL=3'b010
  - FRAME_OVH=6
  - the state encoding: IDLE, RX_START, RX_DATA, RX_CHECK, TURN, TX_START, TX_DATA, TX_STOP
- The master should import the same package.
- One natural sub-module, uart_bit_timer. Inputs: clk, rst, tick, restart, terminal count. Output: a one-clk done strobe. It is instantiated once and reused for half-bit, full-bit and turnaround timing.

Test Plan (all with NBIT_IN=NBIT_OUT=10, BPS=48, START=24, tick every clk):
- Master-model sends payload 10'h2A5, i.e. frame 16'b010_1010100101_101 LSB first. Required: par_data_out=10'h2A5 and one rx_valid pulse. With par_data_in=10'h155 and resp_enable=1, the line shows start 0, then bits of 16'b010_0101010101_101 LSB first, then stop 1. The start bit begins 4*48 ticks after the last receive sample.
- Same frame with head bits corrupted to 3'b100. Required: one frame_err pulse, par_data_out keeps its previous value, ser_oe stays 0.
- 10-tick low glitch on an idle line. Required: frame_err pulse, return to IDLE, no rx_valid.
- resp_enable=0 with a good frame. Required: rx_valid pulses and ser_oe never asserts.
- Assert rst midway through TX_DATA. Required: ser_oe=0 and ser_data_out=1 in the same cycle. The next good frame is received normally.
- Change par_data_in in TX_DATA bit 3. Required: the transmitted frame still carries the value latched at the end of TURN.
